wb_write_queue: RTL and testbench
=================================

// Module: wb_write_queue
// PURPOSE
//   Buffers register write-backs (addr, data, pc) from producers and drains them in order,
//   one per cycle, onto the single GRF write port (we / a3 / wd / pc).
//   Provides two forwarding lookups (rs, rt) that return the newest pending value for an
//   address, so decode sees writes still queued ahead of the GRF.
//   Sits between the WB stage / multi-cycle MDU result path and the GRF write port.
// PARAMETERS
//   DEPTH  4   pending-entry capacity; power of two, 2..16
//   AW     5   register address width
//   DW     32  data and PC width
// PORTS
//   clk       in   1      clock; all state updates on posedge
//   reset     in   1      synchronous, active-low; reset==0 at posedge clears all state
//   in_valid  in   1      producer offers a write this cycle
//   in_ready  out  1      queue accepts; a push happens when in_valid && in_ready
//   in_addr   in   AW     destination register
//   in_data   in   DW     write data
//   in_pc     in   DW     PC of the producing instruction, carried for trace
//   grf_ready in   1      GRF write port is free this cycle
//   grf_we    out  1      write enable to GRF
//   grf_a3    out  AW     write address to GRF
//   grf_wd    out  DW     write data to GRF
//   grf_pc    out  DW     PC of the entry being written
//   rs_addr   in   AW     forwarding lookup 1 address
//   rs_hit    out  1      a pending entry matches rs_addr
//   rs_data   out  DW     data of the newest matching entry, 0 when no hit
//   rt_addr   in   AW     forwarding lookup 2 address
//   rt_hit    out  1      as rs_hit, for rt_addr
//   rt_data   out  DW     as rs_data, for rt_addr
//   count     out  $clog2(DEPTH)+1  number of pending entries
// BEHAVIOUR
//   - Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap
//     modulo DEPTH. count is a separate counter. empty = count==0; full = count==DEPTH.
//   - in_ready = reset && !full. It depends only on registered state, never on pop.
//     When the queue is full, a simultaneous pop does not open a slot in the same cycle.
//   - Push of in_addr==0: handshake completes (the producer sees acceptance) but no entry
//     is stored. $0 never enters the queue.
//   - grf_we = reset && !empty && grf_ready. grf_a3/grf_wd/grf_pc always show the head
//     entry. Outside a write they are 0 when empty.
//   - Pop occurs iff grf_we. Push and pop in the same cycle leave count unchanged.
//   - Latency: an entry pushed into an empty queue at edge N drives grf_we in the cycle
//     after N, given grf_ready. Drain order is strict FIFO.
//   - Duplicate addresses are all kept and all written in order. The last write wins in
//     the GRF.
//   - Lookup is combinational over valid entries only, searched newest to oldest; the
//     first match wins.
//     - addr 0 never hits.
//     - The current-cycle in_* write is NOT visible to lookup.
//     - The head entry being popped this cycle is still visible.
//   - Reset (reset==0 at posedge): count=0, head=tail=0, all pending entries discarded.
//     While reset==0: in_ready=0, grf_we=0, rs_hit=rt_hit=0, data outputs 0.
//     A reset mid-drain loses the remaining entries by design.
//   - The queue never blocks on grf_ready for more than the producer's backpressure.
//     No timeout.
// STRUCTURE
//   - Shared package wb_pkg: REG_AW=5, REG_DW=32, REG_ZERO=5'd0,
//     typedef wb_entry_t {addr, data, pc}.
//   - One sub-module, wb_match: priority search over DEPTH entries plus a valid mask and
//     an age order. Instantiated twice, once for rs and once for rt.
//   - Pointers, counter and storage stay in this module.
// TESTING
//   1. Reset: hold reset=0 with in_valid=1 and addr 5 -> in_ready=0, grf_we=0, count=0;
//      release -> in_ready=1.
//   2. grf_ready=1; push (5,0xAAAA0001,pc 0x3000) -> next cycle grf_we=1, a3=5,
//      wd=0xAAAA0001, pc=0x3000; then count returns to 0.
//   3. grf_ready=0; push 4 entries (r1..r4) -> count=4, in_ready=0.
//      A 5th in_valid is not accepted. Raise grf_ready -> writes r1,r2,r3,r4 on
//      consecutive cycles; the push pointer wraps and a refill of 4 succeeds.
//   4. grf_ready=0; push (7,0x11),(7,0x22) -> rs_addr=7 gives hit=1, data=0x22;
//      rt_addr=8 gives hit=0, data=0. Drain writes 0x11 then 0x22.
//   5. Push addr 0 with data 0xFFFF -> accepted, count stays 0, grf_we never asserted,
//      rs_addr=0 gives no hit.
//   6. With 3 entries pending, pulse reset=0 for one cycle -> count=0, no grf_we follows,
//      lookups miss.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register write-back queue: widths of the GRF port
// and the layout of one pending write.
package wb_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
        logic [REG_DW-1:0] pc;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Forwarding lookup: finds the newest valid entry whose address matches the query.
// Entries are walked oldest to newest starting at head, so the last hit is the newest.
module wb_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             enable,
    input  logic [PW-1:0]    head,
    input  logic [DEPTH-1:0] valid,
    input  logic [AW-1:0]    addrs [DEPTH],
    input  logic [DW-1:0]    datas [DEPTH],
    input  logic [AW-1:0]    query,
    output logic             hit,
    output logic [DW-1:0]    data
);

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int a = 0; a < DEPTH; a++) begin
            idx = head + PW'(a);
            if (enable && query != REG_ZERO && valid[idx] && addrs[idx] == query) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// In-order write-back queue in front of the single GRF write port, with two
// forwarding lookups so decode sees writes that have not reached the GRF yet.
module wb_write_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic [DW-1:0]              in_pc,
    input  logic                       grf_ready,
    output logic                       grf_we,
    output logic [AW-1:0]              grf_a3,
    output logic [DW-1:0]              grf_wd,
    output logic [DW-1:0]              grf_pc,
    input  logic [AW-1:0]              rs_addr,
    output logic                       rs_hit,
    output logic [DW-1:0]              rs_data,
    input  logic [AW-1:0]              rt_addr,
    output logic                       rt_hit,
    output logic [DW-1:0]              rt_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    addrs [DEPTH];
    logic [DW-1:0]    datas [DEPTH];

    assign full       = (cnt == FULL_CNT);
    assign empty      = (cnt == '0);
    assign in_ready   = reset && !full;
    // Writes to $0 complete the handshake but are dropped here.
    assign push       = in_valid && in_ready && (in_addr != REG_ZERO);
    assign head_valid = reset && !empty;
    assign grf_we     = head_valid && grf_ready;
    assign pop        = grf_we;
    assign count      = cnt;

    assign grf_a3 = head_valid ? mem[head].addr : '0;
    assign grf_wd = head_valid ? mem[head].data : '0;
    assign grf_pc = head_valid ? mem[head].pc   : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{addr: in_addr, data: in_data, pc: in_pc};
    end

    // An entry is live when its distance from head is below the pending count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            addrs[i] = mem[i].addr;
            datas[i] = mem[i].data;
            valid[i] = ({1'b0, PW'(i) - head} < cnt);
        end
    end

    wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_match_rs (
        .enable (reset),
        .head   (head),
        .valid  (valid),
        .addrs  (addrs),
        .datas  (datas),
        .query  (rs_addr),
        .hit    (rs_hit),
        .data   (rs_data)
    );

    wb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_match_rt (
        .enable (reset),
        .head   (head),
        .valid  (valid),
        .addrs  (addrs),
        .datas  (datas),
        .query  (rt_addr),
        .hit    (rt_hit),
        .data   (rt_data)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, latency, full/backpressure, wrap,
// forwarding priority, $0 filtering and mid-drain reset.
module tb_wb_write_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic [31:0] in_pc;
    logic        grf_ready;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  rs_addr;
    logic        rs_hit;
    logic [31:0] rs_data;
    logic [4:0]  rt_addr;
    logic        rt_hit;
    logic [31:0] rt_data;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    wb_write_queue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .grf_ready (grf_ready),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc),
        .rs_addr   (rs_addr),
        .rs_hit    (rs_hit),
        .rs_data   (rs_data),
        .rt_addr   (rt_addr),
        .rt_hit    (rt_hit),
        .rt_data   (rt_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_pc    = p;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_addr   = 5'd5;
        in_data   = 32'h0;
        in_pc     = 32'h0;
        grf_ready = 1'b0;
        rs_addr   = 5'd0;
        rt_addr   = 5'd0;

        // 1: reset holds everything idle
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_grf_we", grf_we, 0);
        check("rst_count", count, 0);
        check("rst_a3", grf_a3, 0);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);

        // 2: single write, one-cycle latency
        grf_ready = 1'b1;
        push(5'd5, 32'hAAAA0001, 32'h3000);
        check("lat_we", grf_we, 1);
        check("lat_a3", grf_a3, 5);
        check("lat_wd", grf_wd, 32'hAAAA0001);
        check("lat_pc", grf_pc, 32'h3000);
        check("lat_count1", count, 1);
        tick();
        check("lat_count0", count, 0);
        check("lat_we_off", grf_we, 0);
        check("lat_wd_empty", grf_wd, 0);

        // 3: fill, reject fifth, drain in order, wrap and refill
        grf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i));
        check("full_count", count, 4);
        check("full_ready", in_ready, 0);
        check("full_we", grf_we, 0);
        in_valid = 1'b1;
        in_addr  = 5'd9;
        in_data  = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        check("full_reject_count", count, 4);
        grf_ready = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_we", grf_we, 1);
            check("drain_a3", grf_a3, 64'(i));
            check("drain_wd", grf_wd, 64'(32'h100 + 32'(i)));
            check("drain_pc", grf_pc, 64'(32'h4000 + 32'(4 * i)));
            tick();
        end
        check("drain_count", count, 0);
        check("drain_idle", grf_we, 0);
        grf_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(5'(10 + i), 32'h200 + 32'(i), 32'h5000);
        check("refill_count", count, 4);
        check("refill_head", grf_a3, 10);
        grf_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("refill_a3", grf_a3, 64'(10 + i));
            tick();
        end
        check("refill_empty", count, 0);

        // 4: duplicate address forwarding and ordered drain
        grf_ready = 1'b0;
        push(5'd7, 32'h11, 32'h6000);
        push(5'd7, 32'h22, 32'h6004);
        rs_addr = 5'd7;
        rt_addr = 5'd8;
        in_valid = 1'b1;
        in_addr  = 5'd8;
        in_data  = 32'h99;
        #1;
        check("fwd_rs_hit", rs_hit, 1);
        check("fwd_rs_data", rs_data, 32'h22);
        check("fwd_rt_hit_inflight", rt_hit, 0);
        check("fwd_rt_data", rt_data, 0);
        in_valid  = 1'b0;
        grf_ready = 1'b1;
        #1;
        check("dup_wd1", grf_wd, 32'h11);
        check("dup_rs_newest", rs_data, 32'h22);
        tick();
        check("dup_wd2", grf_wd, 32'h22);
        check("dup_popping_visible", rs_hit, 1);
        tick();
        check("dup_empty", count, 0);
        check("dup_rs_miss", rs_hit, 0);

        // 5: writes to $0 are accepted but never stored
        in_valid = 1'b1;
        in_addr  = 5'd0;
        in_data  = 32'hFFFF;
        rs_addr  = 5'd0;
        #1;
        check("zero_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("zero_count", count, 0);
        check("zero_we", grf_we, 0);
        check("zero_rs_hit", rs_hit, 0);
        tick();
        check("zero_we_later", grf_we, 0);

        // 6: reset mid-queue discards pending entries
        grf_ready = 1'b0;
        push(5'd20, 32'hA0, 32'h7000);
        push(5'd21, 32'hA1, 32'h7004);
        push(5'd22, 32'hA2, 32'h7008);
        rs_addr = 5'd21;
        #1;
        check("pre_rst_count", count, 3);
        check("pre_rst_rs_data", rs_data, 32'hA1);
        reset     = 1'b0;
        grf_ready = 1'b1;
        #1;
        check("in_rst_we", grf_we, 0);
        check("in_rst_rs_hit", rs_hit, 0);
        check("in_rst_ready", in_ready, 0);
        tick();
        reset = 1'b1;
        #1;
        check("post_rst_count", count, 0);
        check("post_rst_we", grf_we, 0);
        check("post_rst_rs_hit", rs_hit, 0);
        tick();
        check("post_rst_we_later", grf_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
